voice_activity_detector: RTL and testbench

VOICE_ACTIVITY_DETECTOR -- requirements
Module: voice_activity_detector

---
 rtl/voice_activity_detector.sv | 125 ++++++++++++
 tb/tb_voice_activity_detector.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_activity_detector.sv
// Frame-energy voice activity detector: accumulates |sample| over FRAME_LEN samples,
// publishes the mean, and runs a hysteresis FSM that tracks utterances and counts them in BCD.
`timescale 1ns/1ps
module voice_activity_detector #(
    parameter int          FRAME_LEN   = 64,
    parameter logic [31:0] ON_THRESH   = 32'd1000,
    parameter logic [31:0] OFF_THRESH  = 32'd500,
    parameter int          HANG_FRAMES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [31:0] filtered_data,
    output logic [31:0] energy,
    output logic        energy_valid,
    output logic        voice_active,
    output logic [3:0]  word_count
);
    localparam int LOG2  = $clog2(FRAME_LEN);
    localparam int ACC_W = 32 + LOG2;
    localparam logic [LOG2-1:0] LAST = LOG2'(FRAME_LEN - 1);

    typedef enum logic [1:0] {SILENT, ONSET, ACTIVE, HANG} state_t;

    logic [LOG2-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d, acc_base;
    logic             done_q, done_d;
    logic [31:0]      energy_q, energy_d;
    logic             ev_q;
    state_t           state_q;
    logic [3:0]       hang_q;
    logic             voice_q;
    logic [3:0]       wc_q;
    logic [31:0]      mag;
    logic             high, low;

    // -2^31 has no positive counterpart in 32 bits, so it clamps to the largest positive value.
    always_comb begin
        if (!filtered_data[31])
            mag = filtered_data;
        else if (filtered_data == 32'h8000_0000)
            mag = 32'h7FFF_FFFF;
        else
            mag = ~filtered_data + 32'd1;
    end

    // The completed sum is held one extra cycle so the divide reads a stable register;
    // a sample arriving on that cycle starts the next frame from zero.
    always_comb begin
        acc_base = done_q ? '0 : acc_q;
        acc_d    = acc_base;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        if (sample_valid) begin
            acc_d  = acc_base + {{LOG2{1'b0}}, mag};
            cnt_d  = cnt_q + 1'b1;
            done_d = (cnt_q == LAST);
        end
        energy_d = done_q ? acc_q[ACC_W-1:LOG2] : energy_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            done_q   <= 1'b0;
            energy_q <= '0;
            ev_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            done_q   <= done_d;
            energy_q <= energy_d;
            ev_q     <= done_q;
        end
    end

    assign high = (energy_q >= ON_THRESH);
    assign low  = (energy_q <  OFF_THRESH);

    // Evaluated once per frame, the cycle energy_valid is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SILENT;
            hang_q  <= '0;
            voice_q <= 1'b0;
            wc_q    <= '0;
        end else if (ev_q) begin
            case (state_q)
                SILENT: if (high) state_q <= ONSET;
                ONSET: begin
                    if (high) begin
                        state_q <= ACTIVE;
                        voice_q <= 1'b1;
                        wc_q    <= (wc_q == 4'd9) ? 4'd0 : wc_q + 4'd1;
                    end else begin
                        state_q <= SILENT;
                    end
                end
                ACTIVE: begin
                    if (low) begin
                        state_q <= HANG;
                        hang_q  <= 4'(HANG_FRAMES - 1);
                    end
                end
                HANG: begin
                    if (!low) begin
                        state_q <= ACTIVE;
                    end else if (hang_q == 4'd0) begin
                        state_q <= SILENT;
                        voice_q <= 1'b0;
                    end else begin
                        hang_q <= hang_q - 4'd1;
                    end
                end
                default: state_q <= SILENT;
            endcase
        end
    end

    assign energy       = energy_q;
    assign energy_valid = ev_q;
    assign voice_active = voice_q;
    assign word_count   = wc_q;
endmodule

// File: tb/tb_voice_activity_detector.sv
// Bench for voice_activity_detector: frame table, hand-written corner sequences, and
// randomized gapped traffic checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_voice_activity_detector;
    localparam int FL   = 64;
    localparam int HANG = 3;
    localparam longint ON  = 1000;
    localparam longint OFF = 500;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic [31:0] filtered_data;
    logic [31:0] energy;
    logic        energy_valid;
    logic        voice_active;
    logic [3:0]  word_count;

    voice_activity_detector #(
        .FRAME_LEN(FL), .ON_THRESH(32'd1000), .OFF_THRESH(32'd500), .HANG_FRAMES(HANG)
    ) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .filtered_data(filtered_data),
        .energy(energy), .energy_valid(energy_valid), .voice_active(voice_active),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: frame means from plain arithmetic, utterance tracking as a low-frame run count.
    longint frame_sum;
    int     frame_n;
    longint exp_q[$];
    bit     m_voice, m_onset;
    int     m_low_run, m_wc;
    int     pulses = 0;
    longint mon_e;

    function automatic longint magf(input logic [31:0] x);
        longint s;
        if (x == 32'h8000_0000) return 64'd2147483647;
        s = longint'($signed(x));
        return (s < 0) ? -s : s;
    endfunction

    task automatic model_clear();
        frame_sum = 0; frame_n = 0; exp_q.delete();
        m_voice = 0; m_onset = 0; m_low_run = 0; m_wc = 0;
    endtask

    task automatic model_accept(input logic [31:0] x);
        frame_sum += magf(x);
        frame_n++;
        if (frame_n == FL) begin
            exp_q.push_back(frame_sum / FL);
            frame_sum = 0;
            frame_n = 0;
        end
    endtask

    task automatic model_frame(input longint e);
        bit hi, lo;
        hi = (e >= ON);
        lo = (e < OFF);
        if (!m_voice) begin
            if (m_onset && hi) begin
                m_voice = 1; m_onset = 0; m_low_run = 0;
                m_wc = (m_wc + 1) % 10;
            end else begin
                m_onset = hi;
            end
        end else if (lo) begin
            m_low_run++;
            if (m_low_run == HANG + 1) begin
                m_voice = 0; m_low_run = 0; m_onset = 0;
            end
        end else begin
            m_low_run = 0;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && energy_valid) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("model_energy", 64'(energy), mon_e);
                    model_frame(mon_e);
                    @(negedge clk);
                    chk("model_voice", 64'(voice_active), 64'(m_voice));
                    chk("model_word_count", 64'(word_count), m_wc);
                end
            end
        end
    end

    // All drive tasks start and finish on a falling edge.
    task automatic send(input logic [31:0] x);
        sample_valid  = 1'b1;
        filtered_data = x;
        @(posedge clk);
        model_accept(x);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int a, input int b);
        for (int k = 0; k < FL; k++) send(32'((k % 2 == 0) ? a : b));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sample_valid = 1'b0;
        gap(2);
        model_clear();
        reset = 1'b0;
        gap(1);
    endtask

    typedef struct {
        int     a;
        int     b;
        longint e;
        bit     v;
        int     wc;
    } vec_t;
    vec_t tbl[17];

    initial begin
        int p0;
        int lvl, v;
        int levels[10];
        tbl[0]  = '{2000, 2000, 2000, 0, 0};
        tbl[1]  = '{1500, -1500, 1500, 1, 1};
        tbl[2]  = '{100, 100, 100, 1, 1};
        tbl[3]  = '{100, 100, 100, 1, 1};
        tbl[4]  = '{600, 600, 600, 1, 1};
        tbl[5]  = '{100, 100, 100, 1, 1};
        tbl[6]  = '{100, 100, 100, 1, 1};
        tbl[7]  = '{100, 100, 100, 1, 1};
        tbl[8]  = '{100, 100, 100, 0, 1};
        tbl[9]  = '{1000, 1000, 1000, 0, 1};
        tbl[10] = '{999, -999, 999, 0, 1};
        tbl[11] = '{1000, 1000, 1000, 0, 1};
        tbl[12] = '{-1000, 1000, 1000, 1, 2};
        tbl[13] = '{500, 500, 500, 1, 2};
        tbl[14] = '{499, 499, 499, 1, 2};
        tbl[15] = '{500, -500, 500, 1, 2};
        tbl[16] = '{3, -4, 3, 1, 2};
        levels = '{0, 300, 499, 500, 800, 999, 1000, 1500, 3000, 100};

        reset = 1'b1;
        sample_valid = 1'b0;
        filtered_data = '0;
        model_clear();
        gap(2);
        chk("reset_energy", 64'(energy), 0);
        chk("reset_energy_valid", 64'(energy_valid), 0);
        chk("reset_voice", 64'(voice_active), 0);
        chk("reset_word_count", 64'(word_count), 0);
        reset = 1'b0;
        gap(1);

        // First frame: exact pulse timing.
        send_frame(2000, 2000);
        chk("pulse_early", 64'(energy_valid), 0);
        gap(1);
        chk("pulse_on_time", 64'(energy_valid), 1);
        chk("first_energy", 64'(energy), 2000);
        gap(1);
        chk("pulse_one_cycle", 64'(energy_valid), 0);
        chk("onset_voice", 64'(voice_active), 0);
        chk("onset_word_count", 64'(word_count), 0);

        do_reset();
        for (int i = 0; i < 17; i++) begin
            send_frame(tbl[i].a, tbl[i].b);
            gap(2);
            chk($sformatf("tbl%0d_energy", i), 64'(energy), tbl[i].e);
            chk($sformatf("tbl%0d_voice", i), 64'(voice_active), 64'(tbl[i].v));
            chk($sformatf("tbl%0d_word_count", i), 64'(word_count), tbl[i].wc);
        end

        do_reset();
        for (int k = 0; k < FL - 1; k++) send(32'd0);
        send(32'h8000_0000);
        gap(2);
        chk("saturated_energy", 64'(energy), 33554431);

        do_reset();
        for (int u = 1; u <= 10; u++) begin
            send_frame(2000, 2000);
            send_frame(2000, -2000);
            gap(2);
            chk($sformatf("utt%0d_voice", u), 64'(voice_active), 1);
            chk($sformatf("utt%0d_word_count", u), 64'(word_count), u % 10);
            for (int f = 0; f < HANG + 1; f++) send_frame(100, 100);
            gap(2);
            chk($sformatf("utt%0d_silent", u), 64'(voice_active), 0);
        end

        do_reset();
        for (int k = 0; k < 30; k++) send(32'd2000);
        do_reset();
        p0 = pulses;
        send_frame(2000, 2000);
        gap(4);
        chk("midreset_pulses", 64'(pulses - p0), 1);
        chk("midreset_energy", 64'(energy), 2000);

        // Randomized gapped traffic; the model tracks energy, voice and count.
        do_reset();
        for (int f = 0; f < 30; f++) begin
            lvl = levels[$urandom_range(0, 9)];
            if ($urandom_range(0, 4) == 0) lvl = int'($urandom_range(0, 2500));
            for (int k = 0; k < FL; k++) begin
                v = lvl + int'($urandom_range(0, 40)) - 20;
                if ($urandom_range(0, 1) == 1) v = -v;
                if ($urandom_range(0, 200) == 0) v = int'(32'h8000_0000);
                send(32'(v));
                gap(int'($urandom_range(0, 5)));
            end
        end
        gap(4);
        chk("pending_frames", 64'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
